// File: rtl/riscv_ctrl_pkg.sv
// Shared types and constants for the RV32 pipeline control blocks.
package riscv_ctrl_pkg;

    // Execute-stage sequencer states.
    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MEM   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } exec_state_t;

    // Register x0 is hard-wired to zero; it is never written and never forwarded.
    localparam logic [4:0] X0 = 5'd0;

    // Fetch redirect value out of reset and the default data-memory timeout.
    localparam logic [31:0] RESETVEC_DEFAULT    = 32'h0000_0000;
    localparam int          MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/exec_ctrl_if.sv
// Bundle of F/D handshake, E/W status, data-memory and redirect signals
// around the execute-stage sequencer.
interface exec_ctrl_if;

    logic        fd_valid;
    logic        fd_ready;
    logic        fd_memwr;
    logic        fd_mem2reg;
    logic        fd_jump;
    logic [4:0]  fd_dst_sel;
    logic [4:0]  fd_src1_sel;
    logic [4:0]  fd_src2_sel;
    logic [31:0] ex_target;
    logic        ex_valid;
    logic        ex_memwr;
    logic        ex_mem2reg;
    logic        ex_jump;
    logic [4:0]  ex_dst_sel;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        dmem_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        wb_valid;
    logic [4:0]  wb_dst_sel;
    logic        fwd_src1;
    logic        fwd_src2;
    logic        trap;

    // The controller side.
    modport slave (
        input  fd_valid, fd_memwr, fd_mem2reg, fd_jump,
        input  fd_dst_sel, fd_src1_sel, fd_src2_sel, ex_target,
        input  dmem_ack, dmem_err,
        output fd_ready, ex_valid, ex_memwr, ex_mem2reg, ex_jump, ex_dst_sel,
        output dmem_req, dmem_we, redirect_valid, redirect_pc,
        output wb_valid, wb_dst_sel, fwd_src1, fwd_src2, trap
    );

    // The pipeline / memory side driving the controller.
    modport master (
        output fd_valid, fd_memwr, fd_mem2reg, fd_jump,
        output fd_dst_sel, fd_src1_sel, fd_src2_sel, ex_target,
        output dmem_ack, dmem_err,
        input  fd_ready, ex_valid, ex_memwr, ex_mem2reg, ex_jump, ex_dst_sel,
        input  dmem_req, dmem_we, redirect_valid, redirect_pc,
        input  wb_valid, wb_dst_sel, fwd_src1, fwd_src2, trap
    );

endinterface

// File: rtl/exec_mem_timer.sv
// Counts MEM cycles without an acknowledge and flags the last permitted one.
module exec_mem_timer
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic resetb,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    // A zero timeout disables expiry; keep a 1-bit counter so widths stay legal.
    localparam int            CW   = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (MEM_TIMEOUT > 0) ? CW'(MEM_TIMEOUT - 1) : '0;

    logic [CW-1:0] r_count;

    // Clear on MEM entry, count each un-acknowledged MEM cycle.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)       r_count <= '0;
        else if (i_clear)  r_count <= '0;
        else if (i_enable) r_count <= r_count + 1'b1;
    end

    assign o_expire = (MEM_TIMEOUT > 0) && i_enable && (r_count == LAST);

endmodule

// File: rtl/exec_ctrl.sv
// Execute-stage sequencer: F/D handshake, E/W registers, data-memory
// handshake, load-use stall, jump redirect, bypass selects and trap.
module exec_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter logic [31:0] RESETVEC    = RESETVEC_DEFAULT,
    parameter int          MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        resetb,
    exec_ctrl_if.slave  bus
);

    exec_state_t r_state;
    exec_state_t w_state_nxt;

    logic       r_ex_valid;
    logic       r_ex_memwr;
    logic       r_ex_mem2reg;
    logic       r_ex_jump;
    logic [4:0] r_ex_dst_sel;
    logic       r_wb_valid;
    logic [4:0] r_wb_dst_sel;
    logic       r_trap;

    logic w_hazard;
    logic w_fd_ready;
    logic w_accept;
    logic w_wb_set;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_expire;

    assign w_hazard = r_ex_valid && r_ex_mem2reg && (r_ex_dst_sel != X0) &&
                      ((r_ex_dst_sel == bus.fd_src1_sel) || (r_ex_dst_sel == bus.fd_src2_sel));

    assign w_accept = bus.fd_valid && w_fd_ready;

    exec_mem_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .resetb   (resetb),
        .i_clear  (w_timer_clear),
        .i_enable (w_timer_en),
        .o_expire (w_expire)
    );

    // Next-state, F/D ready, writeback completion and timer control.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_fd_ready    = 1'b0;
        w_wb_set      = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            RUN: begin
                w_fd_ready = !w_hazard;
                w_wb_set   = r_ex_valid && !r_ex_memwr && !r_ex_mem2reg;
                if (bus.fd_valid && !w_hazard) begin
                    if (bus.fd_memwr || bus.fd_mem2reg) begin
                        w_state_nxt   = MEM;
                        w_timer_clear = 1'b1;
                    end else if (bus.fd_jump) begin
                        w_state_nxt = FLUSH;
                    end
                end
            end
            MEM: begin
                w_timer_en = !bus.dmem_ack;
                if (bus.dmem_err) begin
                    w_state_nxt = HALT;
                end else if (bus.dmem_ack) begin
                    w_state_nxt = RUN;
                    w_wb_set    = r_ex_mem2reg;
                end else if (w_expire) begin
                    w_state_nxt = HALT;
                end
            end
            FLUSH: begin
                w_fd_ready  = 1'b1;
                w_wb_set    = r_ex_valid;
                w_state_nxt = RUN;
            end
            HALT: begin
                w_state_nxt = HALT;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) r_state <= RUN;
        else         r_state <= w_state_nxt;
    end

    // E-stage registers: load on accept in RUN, hold while waiting in MEM, otherwise empty.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_ex_valid   <= 1'b0;
            r_ex_memwr   <= 1'b0;
            r_ex_mem2reg <= 1'b0;
            r_ex_jump    <= 1'b0;
            r_ex_dst_sel <= X0;
        end else if ((r_state == RUN) && w_accept) begin
            r_ex_valid   <= 1'b1;
            r_ex_memwr   <= bus.fd_memwr;
            r_ex_mem2reg <= bus.fd_mem2reg;
            r_ex_jump    <= bus.fd_jump;
            r_ex_dst_sel <= bus.fd_dst_sel;
        end else begin
            r_ex_valid   <= (r_state == MEM) && (w_state_nxt == MEM);
        end
    end

    // W-stage one-cycle write pulse and trap flag.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            r_wb_valid   <= 1'b0;
            r_wb_dst_sel <= X0;
            r_trap       <= 1'b0;
        end else begin
            r_wb_valid <= w_wb_set && (r_ex_dst_sel != X0);
            if (w_wb_set) r_wb_dst_sel <= r_ex_dst_sel;
            r_trap     <= (w_state_nxt == HALT);
        end
    end

    assign bus.fd_ready       = w_fd_ready;
    assign bus.ex_valid       = r_ex_valid;
    assign bus.ex_memwr       = r_ex_memwr;
    assign bus.ex_mem2reg     = r_ex_mem2reg;
    assign bus.ex_jump        = r_ex_jump;
    assign bus.ex_dst_sel     = r_ex_dst_sel;
    assign bus.dmem_req       = (r_state == MEM);
    assign bus.dmem_we        = (r_state == MEM) && r_ex_memwr;
    assign bus.redirect_valid = (r_state == FLUSH);
    assign bus.redirect_pc    = (r_state == FLUSH) ? bus.ex_target : RESETVEC;
    assign bus.wb_valid       = r_wb_valid;
    assign bus.wb_dst_sel     = r_wb_dst_sel;
    assign bus.fwd_src1       = r_wb_valid && (r_wb_dst_sel != X0) && (r_wb_dst_sel == bus.fd_src1_sel);
    assign bus.fwd_src2       = r_wb_valid && (r_wb_dst_sel != X0) && (r_wb_dst_sel == bus.fd_src2_sel);
    assign bus.trap           = r_trap;

endmodule

// File: tb/tb_exec_ctrl.sv
// Directed bench for exec_ctrl: writebacks are checked by a scoreboard
// monitor, control outputs by direct checks in the stimulus thread.
module tb_exec_ctrl;

    logic clk;
    logic resetb;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [4:0] exp_q[$];

    exec_ctrl_if ifc ();

    exec_ctrl #(
        .RESETVEC    (32'h0000_0000),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk    (clk),
        .resetb (resetb),
        .bus    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fd(input logic v, input logic wr, input logic ld, input logic jmp,
                            input logic [4:0] dst, input logic [4:0] s1, input logic [4:0] s2);
        ifc.fd_valid    = v;
        ifc.fd_memwr    = wr;
        ifc.fd_mem2reg  = ld;
        ifc.fd_jump     = jmp;
        ifc.fd_dst_sel  = dst;
        ifc.fd_src1_sel = s1;
        ifc.fd_src2_sel = s2;
    endtask

    // Scoreboard monitor: every writeback pulse must match the oldest expected destination.
    always @(negedge clk) begin
        if (resetb && ifc.wb_valid) begin
            check("wb_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("wb_dst_sel", 32'(ifc.wb_dst_sel), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  req_cycles;
        bit  seen_trap;

        resetb = 1'b0;
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        ifc.ex_target = 32'h0;
        ifc.dmem_ack  = 1'b0;
        ifc.dmem_err  = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_fd_ready", 32'(ifc.fd_ready), 32'd1);
        check("rst_redirect_pc", ifc.redirect_pc, 32'h0);
        check("rst_redirect_valid", 32'(ifc.redirect_valid), 32'd0);
        check("rst_ex_valid", 32'(ifc.ex_valid), 32'd0);
        check("rst_wb_valid", 32'(ifc.wb_valid), 32'd0);
        check("rst_dmem_req", 32'(ifc.dmem_req), 32'd0);
        check("rst_trap", 32'(ifc.trap), 32'd0);
        #2 resetb = 1'b1;

        // ALU op to x5, then a consumer on src1
        step();
        drive_fd(1, 0, 0, 0, 5, 1, 2);
        exp_q.push_back(5'd5);
        @(negedge clk);
        check("alu_fd_ready", 32'(ifc.fd_ready), 32'd1);
        step();
        drive_fd(0, 0, 0, 0, 0, 5, 2);
        @(negedge clk);
        check("alu_ex_valid", 32'(ifc.ex_valid), 32'd1);
        check("alu_ex_dst", 32'(ifc.ex_dst_sel), 32'd5);
        check("alu_fwd1_early", 32'(ifc.fwd_src1), 32'd0);
        step();
        @(negedge clk);
        check("alu_wb_valid", 32'(ifc.wb_valid), 32'd1);
        check("alu_fwd_src1", 32'(ifc.fwd_src1), 32'd1);
        check("alu_fwd_src2", 32'(ifc.fwd_src2), 32'd0);
        step();
        @(negedge clk);
        check("alu_wb_one_pulse", 32'(ifc.wb_valid), 32'd0);

        // Load to x7, dependent on src2, ack in the third MEM cycle
        drive_fd(1, 0, 1, 0, 7, 0, 0);
        exp_q.push_back(5'd7);
        step();
        drive_fd(1, 0, 0, 0, 9, 0, 7);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ifc.dmem_ack = 1'b1;
            @(negedge clk);
            check("ld_fd_ready_stall", 32'(ifc.fd_ready), 32'd0);
            check("ld_dmem_req", 32'(ifc.dmem_req), 32'd1);
            check("ld_dmem_we", 32'(ifc.dmem_we), 32'd0);
            if (i == 0) check("ld_ex_dst_held", 32'(ifc.ex_dst_sel), 32'd7);
            step();
        end
        ifc.dmem_ack = 1'b0;
        exp_q.push_back(5'd9);
        @(negedge clk);
        check("ld_fd_ready_after_ack", 32'(ifc.fd_ready), 32'd1);
        check("ld_fwd_src2", 32'(ifc.fwd_src2), 32'd1);
        check("ld_dmem_req_drop", 32'(ifc.dmem_req), 32'd0);
        check("ld_ex_valid_drop", 32'(ifc.ex_valid), 32'd0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("ld_dep_accepted", 32'(ifc.ex_dst_sel), 32'd9);
        check("ld_dep_ex_valid", 32'(ifc.ex_valid), 32'd1);
        step();
        @(negedge clk);

        // JAL to x1, target 0x100; the instruction behind it is discarded
        drive_fd(1, 0, 0, 1, 1, 0, 0);
        ifc.ex_target = 32'h0000_0100;
        step();
        drive_fd(1, 0, 0, 0, 12, 0, 0);
        exp_q.push_back(5'd1);
        @(negedge clk);
        check("jmp_redirect_valid", 32'(ifc.redirect_valid), 32'd1);
        check("jmp_redirect_pc", ifc.redirect_pc, 32'h0000_0100);
        check("jmp_fd_ready", 32'(ifc.fd_ready), 32'd1);
        check("jmp_ex_jump", 32'(ifc.ex_jump), 32'd1);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("jmp_discard_ex_valid", 32'(ifc.ex_valid), 32'd0);
        check("jmp_redirect_drop", 32'(ifc.redirect_valid), 32'd0);
        check("jmp_redirect_pc_idle", ifc.redirect_pc, 32'h0);
        step();
        @(negedge clk);

        // Load to x0, acked in the first MEM cycle
        drive_fd(1, 0, 1, 0, 0, 0, 0);
        step();
        drive_fd(1, 0, 0, 0, 3, 0, 0);
        ifc.dmem_ack = 1'b1;
        @(negedge clk);
        check("x0_dmem_req", 32'(ifc.dmem_req), 32'd1);
        step();
        ifc.dmem_ack = 1'b0;
        exp_q.push_back(5'd3);
        @(negedge clk);
        check("x0_no_stall", 32'(ifc.fd_ready), 32'd1);
        check("x0_no_wb", 32'(ifc.wb_valid), 32'd0);
        check("x0_no_fwd", 32'(ifc.fwd_src1), 32'd0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("x0_next_accepted", 32'(ifc.ex_dst_sel), 32'd3);
        step();
        @(negedge clk);

        // Store acked in the 16th MEM cycle: ack beats the timeout
        drive_fd(1, 1, 0, 0, 4, 0, 0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) ifc.dmem_ack = 1'b1;
            @(negedge clk);
            if (i == 0) check("st_dmem_we", 32'(ifc.dmem_we), 32'd1);
            step();
        end
        ifc.dmem_ack = 1'b0;
        @(negedge clk);
        check("to_ack_wins_trap", 32'(ifc.trap), 32'd0);
        check("to_ack_wins_ready", 32'(ifc.fd_ready), 32'd1);
        check("to_ack_wins_req", 32'(ifc.dmem_req), 32'd0);

        // Store never acked: trap after 16 MEM cycles
        drive_fd(1, 1, 0, 0, 4, 0, 0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        req_cycles = 0;
        seen_trap  = 1'b0;
        for (int i = 0; i < 40 && !seen_trap; i++) begin
            @(negedge clk);
            if (ifc.trap) seen_trap = 1'b1;
            else if (ifc.dmem_req) req_cycles++;
        end
        check("to_trap_seen", 32'(seen_trap), 32'd1);
        check("to_mem_cycles", 32'(req_cycles), 32'd16);
        drive_fd(1, 0, 0, 0, 2, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halt_trap", 32'(ifc.trap), 32'd1);
            check("halt_fd_ready", 32'(ifc.fd_ready), 32'd0);
            check("halt_ex_valid", 32'(ifc.ex_valid), 32'd0);
            check("halt_dmem_req", 32'(ifc.dmem_req), 32'd0);
        end
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        #2 resetb = 1'b0;
        #1;
        check("halt_reset_trap", 32'(ifc.trap), 32'd0);
        @(negedge clk);
        #2 resetb = 1'b1;

        // Reset asserted mid-MEM
        step();
        drive_fd(1, 0, 1, 0, 8, 0, 0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rmem_dmem_req", 32'(ifc.dmem_req), 32'd1);
        #2 resetb = 1'b0;
        #1;
        check("rmem_async_req_drop", 32'(ifc.dmem_req), 32'd0);
        @(negedge clk);
        #2 resetb = 1'b1;
        @(negedge clk);
        check("rmem_fd_ready", 32'(ifc.fd_ready), 32'd1);
        check("rmem_redirect_pc", ifc.redirect_pc, 32'h0);
        check("rmem_ex_valid", 32'(ifc.ex_valid), 32'd0);
        check("rmem_dmem_req", 32'(ifc.dmem_req), 32'd0);

        // Load with ack and err in the same cycle: error wins
        step();
        drive_fd(1, 0, 1, 0, 6, 0, 0);
        step();
        drive_fd(0, 0, 0, 0, 0, 0, 0);
        ifc.dmem_ack = 1'b1;
        ifc.dmem_err = 1'b1;
        @(negedge clk);
        check("err_dmem_req", 32'(ifc.dmem_req), 32'd1);
        step();
        ifc.dmem_ack = 1'b0;
        ifc.dmem_err = 1'b0;
        @(negedge clk);
        check("err_trap", 32'(ifc.trap), 32'd1);
        check("err_no_wb", 32'(ifc.wb_valid), 32'd0);
        check("err_fd_ready", 32'(ifc.fd_ready), 32'd0);
        check("err_ex_valid", 32'(ifc.ex_valid), 32'd0);
        step();
        @(negedge clk);

        check("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
